execute_writeback: RTL and testbench

EXECUTE_WRITEBACK -- requirements
Module: execute_writeback

---
 rtl/execute_writeback_pkg.sv | 26 ++
 rtl/execute_writeback_alu.sv | 25 ++
 rtl/execute_writeback.sv | 164 ++++++++++++++++
 tb/tb_execute_writeback.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/execute_writeback_pkg.sv
// Shared ALU operation codes, FSM state encoding and control helpers for the
// execute/writeback block.
package execute_writeback_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MEM  = 2'b10,
    ST_WB   = 2'b11
  } state_t;

  // Exactly one of read/write needs a memory transaction.
  function automatic logic needs_mem(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

  function automatic logic mem_conflict(input logic rd, input logic wr);
    return rd & wr;
  endfunction

endpackage

// File: rtl/execute_writeback_alu.sv
// Combinational 64-bit ALU: AND/OR/ADD/SUB; any other code yields 0 and flags invalid.
module alu64
  import execute_writeback_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  alu_control_signal,
  output logic [63:0] result,
  output logic        invalid
);

  // Operation decode; ADD/SUB wrap naturally at 64 bits.
  always_comb begin
    result  = 64'd0;
    invalid = 1'b0;
    case (alu_control_signal)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_writeback.sv
// Multi-cycle execute / memory / writeback stage. All outputs are registered
// against the next state so they line up with the state they belong to.
module execute_writeback
  import execute_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] rd1,
  input  logic [63:0] rd2,
  input  logic [63:0] imm,
  input  logic        alu_src,
  input  logic [4:0]  write_addr,
  input  logic [3:0]  alu_control_signal,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        Branch,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic        err
);

  state_t      state_r, state_next_s;
  logic        exec_stage_r;
  logic [63:0] rd1_r, rd2_r, imm_r;
  logic        alu_src_r;
  logic [4:0]  waddr_r;
  logic [3:0]  op_r;
  logic        reg_write_r, mem_read_r, memto_reg_r, mem_write_r, branch_r;
  logic [63:0] alu_b_s, alu_result_s, alu_r, load_r, wb_data_s;
  logic        alu_invalid_s, err_flag_r;
  logic        accept_s, enter_mem_s, enter_wb_s;
  logic        in_ready_r, mem_req_r, mem_we_r, rf_we_r;
  logic        branch_valid_r, branch_taken_r, err_r;
  logic [63:0] mem_addr_r, mem_wdata_r, rf_wdata_r;
  logic [4:0]  rf_waddr_r;

  assign alu_b_s = alu_src_r ? imm_r : rd2_r;

  alu64 u_alu (
    .a                  (rd1_r),
    .b                  (alu_b_s),
    .alu_control_signal (op_r),
    .result             (alu_result_s),
    .invalid            (alu_invalid_s)
  );

  // Next-state decode; EXEC spends one cycle registering the ALU result and
  // a second cycle launching into MEM or WB.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_next_s = ST_EXEC;
        else          state_next_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (exec_stage_r) state_next_s = needs_mem(mem_read_r, mem_write_r) ? ST_MEM : ST_WB;
        else              state_next_s = ST_EXEC;
      end
      ST_MEM: begin
        if (mem_ack) state_next_s = ST_WB;
        else         state_next_s = ST_MEM;
      end
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign accept_s    = (state_r == ST_IDLE) && in_valid;
  assign enter_mem_s = (state_r == ST_EXEC) && (state_next_s == ST_MEM);
  assign enter_wb_s  = (state_next_s == ST_WB);
  // On the ack edge the load data is taken straight from the bus.
  assign wb_data_s   = memto_reg_r ? ((state_r == ST_MEM) ? mem_rdata : load_r) : alu_r;

  // State register and EXEC sub-cycle flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      exec_stage_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      exec_stage_r <= (state_r == ST_EXEC) && !exec_stage_r;
    end
  end

  // Instruction latch on acceptance, load-data latch on memory completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_r <= 64'd0; rd2_r <= 64'd0; imm_r <= 64'd0; alu_src_r <= 1'b0;
      waddr_r <= 5'd0; op_r <= 4'd0; reg_write_r <= 1'b0; mem_read_r <= 1'b0;
      memto_reg_r <= 1'b0; mem_write_r <= 1'b0; branch_r <= 1'b0; load_r <= 64'd0;
    end else if (accept_s) begin
      rd1_r <= rd1; rd2_r <= rd2; imm_r <= imm; alu_src_r <= alu_src;
      waddr_r <= write_addr; op_r <= alu_control_signal; reg_write_r <= RegWrite;
      mem_read_r <= MemRead; memto_reg_r <= MemtoReg; mem_write_r <= MemWrite;
      branch_r <= Branch; load_r <= 64'd0;
    end else if ((state_r == ST_MEM) && mem_ack) begin
      load_r <= mem_rdata;
    end
  end

  // ALU result and error flag, captured in the first EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_r      <= 64'd0;
      err_flag_r <= 1'b0;
    end else if ((state_r == ST_EXEC) && !exec_stage_r) begin
      alu_r      <= alu_result_s;
      err_flag_r <= alu_invalid_s | mem_conflict(mem_read_r, mem_write_r);
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r <= 1'b1; mem_req_r <= 1'b0; mem_we_r <= 1'b0;
      mem_addr_r <= 64'd0; mem_wdata_r <= 64'd0; rf_we_r <= 1'b0;
      rf_waddr_r <= 5'd0; rf_wdata_r <= 64'd0; branch_valid_r <= 1'b0;
      branch_taken_r <= 1'b0; err_r <= 1'b0;
    end else begin
      in_ready_r     <= (state_next_s == ST_IDLE);
      mem_req_r      <= (state_next_s == ST_MEM);
      mem_we_r       <= (state_next_s == ST_MEM) && mem_write_r;
      rf_we_r        <= enter_wb_s && reg_write_r && (waddr_r != 5'd0);
      branch_valid_r <= enter_wb_s && branch_r;
      branch_taken_r <= enter_wb_s && branch_r && (alu_r == 64'd0);
      err_r          <= enter_wb_s && err_flag_r;
      if (enter_mem_s) begin
        mem_addr_r  <= alu_r;
        mem_wdata_r <= rd2_r;
      end
      if (enter_wb_s) begin
        rf_waddr_r <= waddr_r;
        rf_wdata_r <= wb_data_s;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign branch_valid = branch_valid_r;
  assign branch_taken = branch_taken_r;
  assign err          = err_r;

endmodule

// File: tb/tb_execute_writeback.sv
// Directed self-checking bench for execute_writeback: ALU ops, loads/stores,
// branch resolution, error cases, x0 writes and reset during a memory access.
module tb_execute_writeback;

  logic        clk, reset, in_valid, in_ready;
  logic [63:0] rd1, rd2, imm;
  logic        alu_src;
  logic [4:0]  write_addr;
  logic [3:0]  alu_control_signal;
  logic        RegWrite, MemRead, MemtoReg, MemWrite, Branch;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        rf_we, branch_valid, branch_taken, err;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  int          wb_idx, rdy_idx, req_cnt, err_cnt, we_cnt;
  logic        bv_seen, bt_seen, mwe_seen;
  logic [63:0] got_addr, got_wdata, got_rfd;
  logic [4:0]  got_rfa;

  execute_writeback dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2(rd2), .imm(imm), .alu_src(alu_src), .write_addr(write_addr),
    .alu_control_signal(alu_control_signal), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Branch(Branch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .branch_valid(branch_valid), .branch_taken(branch_taken), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // Issue one instruction, then watch every negedge until in_ready returns.
  // Index 0 is the negedge right after the accepting edge.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] im, input logic src, input logic [4:0] wa,
                        input logic rw, input logic mr, input logic mtr, input logic mw,
                        input logic br, input int ack_after, input logic [63:0] rdata);
    @(negedge clk);
    alu_control_signal = op; rd1 = a; rd2 = b; imm = im; alu_src = src; write_addr = wa;
    RegWrite = rw; MemRead = mr; MemtoReg = mtr; MemWrite = mw; Branch = br;
    in_valid = 1'b1;
    @(posedge clk);
    wb_idx = -1; rdy_idx = -1; req_cnt = 0; err_cnt = 0; we_cnt = 0;
    bv_seen = 1'b0; bt_seen = 1'b0; mwe_seen = 1'b0;
    got_addr = 64'd0; got_wdata = 64'd0; got_rfd = 64'd0; got_rfa = 5'd0;
    for (int i = 0; i < 40 && rdy_idx < 0; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (rf_we) begin
        we_cnt++;
        if (wb_idx < 0) wb_idx = i;
        got_rfa = rf_waddr; got_rfd = rf_wdata;
      end
      if (branch_valid) begin bv_seen = 1'b1; bt_seen = branch_taken; end
      if (err) err_cnt++;
      if (mem_req) begin
        req_cnt++;
        got_addr = mem_addr; got_wdata = mem_wdata;
        if (mem_we) mwe_seen = 1'b1;
      end
      if (mem_req && req_cnt == ack_after) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_ack = 1'b0; mem_rdata = 64'd0;
      end
      if (in_ready) rdy_idx = i;
    end
    check("op_done_in_budget", 64'(rdy_idx >= 0), 64'd1);
  endtask

  initial begin
    logic stray_bad;
    reset = 1'b1; in_valid = 1'b0; rd1 = 64'd0; rd2 = 64'd0; imm = 64'd0; alu_src = 1'b0;
    write_addr = 5'd0; alu_control_signal = 4'd0; RegWrite = 1'b0; MemRead = 1'b0;
    MemtoReg = 1'b0; MemWrite = 1'b0; Branch = 1'b0; mem_ack = 1'b0; mem_rdata = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rf_we",    64'(rf_we),    64'd0);
    check("rst_mem_req",  64'(mem_req),  64'd0);
    check("rst_err",      64'(err),      64'd0);
    check("rst_rf_wdata", rf_wdata,      64'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADD 5+7 -> x3, exact latency
    run_op(4'b0010, 64'd5, 64'd7, 64'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    check("add_wb_idx",  64'(wb_idx),  64'd2);
    check("add_rdy_idx", 64'(rdy_idx), 64'd3);
    check("add_we_cnt",  64'(we_cnt),  64'd1);
    check("add_waddr",   64'(got_rfa), 64'd3);
    check("add_wdata",   got_rfd,      64'd12);
    check("add_no_req",  64'(req_cnt), 64'd0);

    // SUB 0-1 wraps
    run_op(4'b0110, 64'd0, 64'd1, 64'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    check("sub_wdata", got_rfd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sub_no_bv", 64'(bv_seen), 64'd0);

    // Branch taken (9-9==0) and not taken (9-8)
    run_op(4'b0110, 64'd9, 64'd9, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 64'd0);
    check("br_valid", 64'(bv_seen), 64'd1);
    check("br_taken", 64'(bt_seen), 64'd1);
    check("br_no_we", 64'(we_cnt),  64'd0);
    run_op(4'b0110, 64'd9, 64'd8, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 64'd0);
    check("brn_valid", 64'(bv_seen), 64'd1);
    check("brn_taken", 64'(bt_seen), 64'd0);

    // AND, OR with immediate operand, ADD wrap
    run_op(4'b0000, 64'hF0F0, 64'hFF00, 64'h000F, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    check("and_wdata", got_rfd, 64'hF000);
    run_op(4'b0001, 64'hF0F0, 64'hFF00, 64'h000F, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    check("or_imm_wdata", got_rfd, 64'hF0FF);
    run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    check("add_wrap_wdata", got_rfd, 64'd1);

    // Load: addr 0x100+8, ack on the third request cycle
    run_op(4'b0010, 64'h100, 64'd0, 64'd8, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 64'hDEAD);
    check("ld_req_cycles", 64'(req_cnt),  64'd3);
    check("ld_addr",       got_addr,      64'h108);
    check("ld_not_write",  64'(mwe_seen), 64'd0);
    check("ld_wb_idx",     64'(wb_idx),   64'd5);
    check("ld_waddr",      64'(got_rfa),  64'd5);
    check("ld_wdata",      got_rfd,       64'hDEAD);

    // Store: 0x200+0x10 <- 0xAA
    run_op(4'b0010, 64'h200, 64'hAA, 64'h10, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 64'd0);
    check("st_we",      64'(mwe_seen), 64'd1);
    check("st_wdata",   got_wdata,     64'hAA);
    check("st_addr",    got_addr,      64'h210);
    check("st_no_rfwe", 64'(we_cnt),   64'd0);
    check("st_rdy_idx", 64'(rdy_idx),  64'd4);

    // Invalid ALU code: result 0, single err pulse
    run_op(4'b1111, 64'd3, 64'd4, 64'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    check("inv_err_pulse", 64'(err_cnt), 64'd1);
    check("inv_no_req",    64'(req_cnt), 64'd0);
    check("inv_wdata",     got_rfd,      64'd0);

    // MemRead && MemWrite: skips MEM, errors in WB
    run_op(4'b0010, 64'd1, 64'd2, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 64'd0);
    check("rw_err_pulse", 64'(err_cnt), 64'd1);
    check("rw_no_req",    64'(req_cnt), 64'd0);
    check("rw_rdy_idx",   64'(rdy_idx), 64'd3);

    // Write to x0
    run_op(4'b0010, 64'd1, 64'd1, 64'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    check("x0_no_we",  64'(we_cnt),  64'd0);
    check("x0_rdy_idx", 64'(rdy_idx), 64'd3);

    // Reset mid-MEM: mem_req drops without a clock edge
    @(negedge clk);
    alu_control_signal = 4'b0010; rd1 = 64'h40; imm = 64'd0; alu_src = 1'b1; write_addr = 5'd2;
    RegWrite = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; MemWrite = 1'b0; Branch = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    check("rstmem_req_up", 64'(mem_req), 64'd1);
    reset = 1'b1;
    #1;
    check("rstmem_req_low", 64'(mem_req),  64'd0);
    check("rstmem_ready",   64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'hBEEF;
    stray_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rf_we || mem_req || err || !in_ready) stray_bad = 1'b1;
    end
    check("stray_ack_ignored", 64'(stray_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
